seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
Word-level controller and scheduler for an overlapping Mealy pattern detector. Accepts parallel words over a valid/ready handshake and serializes each word MSB-first, one bit per cycle, through an embedded programmable-pattern Mealy detector. Counts matches per word and reports the count with a done pulse. The pattern and the overlap mode are programmable while the block is idle, so one detector serves any 1010-style pattern without a redesign.

Parameters:
WORD_W, 8, width of each input word (number of serialized bits, >= PAT_W)
PAT_W, 4, pattern length in bits (>= 2)
CNT_W, 4, match counter width; the counter saturates

Ports:
clk  input  1  clock; all flops update on the rising edge
rst  input  1  asynchronous reset, active-low: 0 resets immediately, release is synchronous to clk
cfg_we  input  1  config write strobe; honoured only in IDLE
cfg_pattern  input  PAT_W  pattern to detect; the first-received bit is the MSB
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
in_valid  input  1  input word valid
in_data  input  WORD_W  word to scan; sent MSB first
in_ready  output  1  block can accept a word
bit_out  output  1  serial bit currently being checked (0 when not in SHIFT)
match  output  1  Mealy output; high in the SHIFT cycle whose bit completes the pattern
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse after the last bit of a word
match_count  output  CNT_W  matches found in the last word; held until the next word is accepted

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state to IDLE
  - pattern register to the low PAT_W bits of 1010 repeated (4'b1010 at the default PAT_W)
  - overlap register to 1
  - history, fill counter, bit index and match_count to 0
  - outputs: in_ready=1, busy=0, done=0, match=0, bit_out=0
- States:
  - IDLE: in_ready=1.
    - cfg_we=1 loads the pattern and overlap registers at the clock edge.
    - in_valid=1 (a handshake, since in_ready=1) captures in_data, clears history, fill count and match_count, sets bit index to WORD_W-1, and moves to SHIFT.
    - If cfg_we and in_valid are both high in the same cycle, the config takes effect first and the captured word uses the new config.
  - SHIFT: in_ready=0, bit_out = word[idx].
    - Each cycle: history <= {history[PAT_W-3:0], bit_out}, fill count increments and saturates at PAT_W-1, idx decrements.
    - When idx=0, move to DONE.
  - DONE: in_ready=0, done=1 for exactly one cycle; next state is IDLE.
- Match rule (combinational, SHIFT only): match = (fill >= PAT_W-1) and ({history[PAT_W-2:0], bit_out} == pattern).
- On a match:
  - match_count increments and saturates at 2^CNT_W-1.
  - If overlap=0, fill count is cleared to 0, so history before the match is ignored.
  - If overlap=1, history continues unchanged.
- Detection never spans two words.
- cfg_we in SHIFT or DONE is ignored; the config stays stable while a word is being scanned.
- Timing: handshake at edge T; bits appear in cycles T+1 to T+WORD_W; done in cycle T+WORD_W+1; in_ready=1 again in cycle T+WORD_W+2. Throughput is one word per WORD_W+2 cycles.
- match_count is valid while done=1 and is held through IDLE until the next handshake.
- Reset asserted mid-SHIFT aborts the word immediately. No done pulse is produced and all state returns to the reset values.

Test Plan:
- Reset defaults: hold rst=0 for 2 cycles, then release -> in_ready=1, busy=0, done=0, match=0, match_count=0; a word scanned with no config write uses pattern 1010 with overlap on.
- Overlap on, in_data=8'b10101010 -> match high on bits 4, 6 and 8 (cycles T+4, T+6, T+8); done at T+9 with match_count=3; in_ready=1 at T+10.
- Overlap off (cfg_overlap=0 written in IDLE), in_data=8'b10101010 -> match at bits 4 and 8 only; match_count=2.
- Pattern 1010 with overlap on, in_data=8'b10100101 -> one match at bit 4; match_count=1. Then a back-to-back word 8'b00000000 with in_valid held -> accepted at T+10, match_count=0, proving no cross-word history.
- Config write during SHIFT (cfg_pattern=4'b1111) -> ignored; the current and next words still detect 1010. Saturation: CNT_W=2, WORD_W=16, word 16'hAAAA with overlap on -> 7 raw matches, match_count=3.
- Reset mid-word: assert rst=0 at T+3 -> in_ready=1 and match_count=0 immediately, no done pulse; a subsequent 8'b10101010 gives match_count=3.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Word-level scheduler around a programmable overlapping Mealy pattern detector.
// Words arrive over valid/ready and are scanned MSB-first, one bit per cycle.
module seq_detect_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              bit_out,
  output logic              match,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_count
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(PAT_W);

  localparam logic [2*PAT_W-1:0] PAT_REP   = {PAT_W{2'b10}};
  localparam logic [PAT_W-1:0]   RST_PAT   = PAT_REP[PAT_W-1:0];
  localparam logic [FILL_W-1:0]  FILL_MAX  = FILL_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0]   IDX_FIRST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [PAT_W-1:0]  pattern_q;
  logic              overlap_q;
  logic [WORD_W-1:0] word_q;
  logic [PAT_W-2:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              shift_bit;
  logic [PAT_W-1:0]  window;
  logic              hit;
  logic [FILL_W-1:0] fill_inc;

  // The window is built from the full history plus the current bit so the
  // shift also works at the minimum pattern length of 2.
  assign shift_bit = word_q[idx_q];
  assign window    = {hist_q, shift_bit};
  assign hit       = (state == SHIFT) && (fill_q >= FILL_MAX) && (window == pattern_q);
  assign fill_inc  = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (in_valid) next_state = SHIFT;
      SHIFT:   if (idx_q == '0) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    bit_out  = 1'b0;
    match    = 1'b0;
    unique case (state)
      IDLE: in_ready = 1'b1;
      SHIFT: begin
        busy    = 1'b1;
        bit_out = shift_bit;
        match   = hit;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= RST_PAT;
      overlap_q <= 1'b1;
      word_q    <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_we) begin
            pattern_q <= cfg_pattern;
            overlap_q <= cfg_overlap;
          end
          if (in_valid) begin
            word_q <= in_data;
            hist_q <= '0;
            fill_q <= '0;
            idx_q  <= IDX_FIRST;
            cnt_q  <= '0;
          end
        end
        SHIFT: begin
          hist_q <= window[PAT_W-2:0];
          idx_q  <= idx_q - 1'b1;
          if (hit) begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            fill_q <= overlap_q ? fill_inc : '0;
          end else begin
            fill_q <= fill_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign match_count = cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: vector table plus hand-written corner sequences.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       cfg_we;
  logic [3:0] cfg_pattern;
  logic       cfg_overlap;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready, bit_out, match, busy, done;
  logic [3:0] match_count;

  logic        s_cfg_we;
  logic [3:0]  s_pattern;
  logic        s_overlap;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready, s_bit, s_match, s_busy, s_done;
  logic [1:0]  s_count;

  seq_detect_ctrl #(.WORD_W(8), .PAT_W(4), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bit_out(bit_out), .match(match), .busy(busy),
    .done(done), .match_count(match_count)
  );

  seq_detect_ctrl #(.WORD_W(16), .PAT_W(4), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .cfg_we(s_cfg_we), .cfg_pattern(s_pattern),
    .cfg_overlap(s_overlap), .in_valid(s_valid), .in_data(s_data),
    .in_ready(s_ready), .bit_out(s_bit), .match(s_match), .busy(s_busy),
    .done(s_done), .match_count(s_count)
  );

  typedef struct {
    logic [1:0] cfg_mode;   // 0 none, 1 write before handshake, 2 write in handshake cycle
    logic [3:0] pat;
    logic       ovl;
    logic [7:0] data;
    logic [7:0] mask;       // bit 7 = first serialized bit
    int unsigned cnt;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Entered just after a negedge with the DUT in IDLE; leaves in the IDLE
  // cycle after DONE so consecutive calls run back to back.
  task automatic scan_word(input int unsigned vid, input logic [1:0] cfg_mode,
                           input logic [3:0] pat, input logic ovl,
                           input logic [7:0] data, input logic [7:0] mask,
                           input int unsigned cnt, input logic keep_valid,
                           input logic cfg_during);
    if (cfg_mode == 2'd1) begin
      cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ovl;
      @(negedge clk);
      cfg_we = 1'b0;
    end
    check($sformatf("v%0d ready_before", vid), in_ready, 1);
    if (cfg_mode == 2'd2) begin
      cfg_we = 1'b1; cfg_pattern = pat; cfg_overlap = ovl;
    end
    in_valid = 1'b1; in_data = data;
    @(negedge clk);
    cfg_we   = 1'b0;
    in_valid = keep_valid;
    if (cfg_during) begin
      cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      check($sformatf("v%0d bit_out[%0d]", vid, i), bit_out, data[7-i]);
      check($sformatf("v%0d match[%0d]", vid, i), match, mask[7-i]);
      check($sformatf("v%0d busy[%0d]", vid, i), {busy, in_ready, done}, 3'b100);
      @(negedge clk);
    end
    check($sformatf("v%0d done", vid), {done, busy, in_ready, match, bit_out}, 5'b11000);
    check($sformatf("v%0d count", vid), match_count, cnt);
    @(negedge clk);
    cfg_we = 1'b0;
    check($sformatf("v%0d idle_after", vid), {in_ready, busy, done}, 3'b100);
    check($sformatf("v%0d count_held", vid), match_count, cnt);
  endtask

  vec_t vt[6];
  int unsigned raw;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{2'd0, 4'b1010, 1'b1, 8'b10101010, 8'b00010101, 3};
    vt[1] = '{2'd1, 4'b1010, 1'b0, 8'b10101010, 8'b00010001, 2};
    vt[2] = '{2'd1, 4'b0110, 1'b1, 8'b01101101, 8'b00010010, 2};
    vt[3] = '{2'd2, 4'b1111, 1'b0, 8'b11111111, 8'b00010001, 2};
    vt[4] = '{2'd1, 4'b1111, 1'b1, 8'b11111111, 8'b00011111, 5};
    vt[5] = '{2'd2, 4'b1010, 1'b1, 8'b10100101, 8'b00010000, 1};

    rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = '0;
    s_cfg_we = 1'b0; s_pattern = '0; s_overlap = 1'b0; s_valid = 1'b0; s_data = '0;

    repeat (2) @(negedge clk);
    check("reset_outputs", {in_ready, busy, done, match, bit_out}, 5'b10000);
    check("reset_count", match_count, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {in_ready, busy, done, match, bit_out}, 5'b10000);
    check("post_reset_count", match_count, 0);

    for (int v = 0; v < 6; v++)
      scan_word(v, vt[v].cfg_mode, vt[v].pat, vt[v].ovl, vt[v].data,
                vt[v].mask, vt[v].cnt, (v == 5), 1'b0);

    // in_valid still high: the zero word is accepted on the first IDLE edge
    scan_word(10, 2'd0, 4'b0000, 1'b0, 8'b00000000, 8'b00000000, 0, 1'b0, 1'b0);

    // config writes while scanning must not disturb this or the next word
    scan_word(11, 2'd0, 4'b0000, 1'b0, 8'b10101010, 8'b00010101, 3, 1'b0, 1'b1);
    scan_word(12, 2'd0, 4'b0000, 1'b0, 8'b10101010, 8'b00010101, 3, 1'b0, 1'b0);

    // abort mid-word with overlap turned off beforehand; reset restores overlap
    cfg_we = 1'b1; cfg_pattern = 4'b1010; cfg_overlap = 1'b0;
    @(negedge clk);
    cfg_we = 1'b0; in_valid = 1'b1; in_data = 8'b10101010;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    check("abort_outputs", {in_ready, busy, done, match, bit_out}, 5'b10000);
    check("abort_count", match_count, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("abort_no_done[%0d]", i), {done, busy, in_ready}, 3'b001);
    end
    scan_word(20, 2'd0, 4'b0000, 1'b0, 8'b10101010, 8'b00010101, 3, 1'b0, 1'b0);

    // saturation on the 16-bit, 2-bit-counter instance
    check("sat_ready", s_ready, 1);
    s_valid = 1'b1; s_data = 16'hAAAA;
    @(negedge clk);
    s_valid = 1'b0;
    raw = 0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("sat_busy[%0d]", i), {s_busy, s_done}, 2'b10);
      raw += s_match;
      @(negedge clk);
    end
    check("sat_raw_matches", raw, 7);
    check("sat_done", s_done, 1);
    check("sat_count", s_count, 3);
    @(negedge clk);
    check("sat_idle", {s_ready, s_busy, s_done}, 3'b100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
